// File: rtl/tile_transfer_engine_if.sv
// Avalon-MM master bus bundle for the tile transfer engine.
// A read or write is accepted on a rising edge where its strobe is high and avm_waitrequest is low;
// address, strobe and write data are held until then.
interface tile_transfer_engine_if #(
  parameter int DW = 32
);
  logic [DW-1:0] avm_address;
  logic          avm_read;
  logic          avm_write;
  logic [DW-1:0] avm_writedata;
  logic [DW-1:0] avm_readdata;
  logic          avm_readdatavalid;
  logic          avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_readdatavalid, avm_waitrequest
  );
endinterface

// File: rtl/tile_transfer_engine.sv
// Copies one tile of iolen words from raddr to waddr per config_done pulse,
// staging the tile in an internal buffer; pulses store_data_done when finished.
module tile_transfer_engine #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   config_done,
  input  logic [DW-1:0]          param_raddr,
  input  logic [DW-1:0]          param_waddr,
  input  logic [AW-1:0]          param_iolen,
  output logic                   store_data_done,
  output logic                   busy,
  output logic [2:0]             dbg_state,
  tile_transfer_engine_if.master avm
);

  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_WR_LD = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] raddr_q, raddr_d;
  logic [DW-1:0] waddr_q, waddr_d;
  logic [CW-1:0] iolen_q, iolen_d;
  logic [CW-1:0] rd_issued_q, rd_issued_d;
  logic [CW-1:0] rd_recv_q, rd_recv_d;
  logic [CW-1:0] wr_sent_q, wr_sent_d;
  logic [DW-1:0] addr_q, addr_d;
  logic          read_q, read_d;
  logic          write_q, write_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;
  logic [DW-1:0] wdata_q;

  logic [DW-1:0] buf_mem [2**AW];

  logic          rd_acc;
  logic          wr_acc;
  logic          rdv_acc;
  logic          buf_rd_en;
  logic [CW-1:0] rd_issued_nxt;
  logic [CW-1:0] rd_recv_nxt;
  logic [CW-1:0] iolen_m1;

  assign rd_acc        = read_q && !avm.avm_waitrequest;
  assign wr_acc        = write_q && !avm.avm_waitrequest;
  // Read data is only taken while reading and before the tile is complete.
  assign rdv_acc       = (state_q == S_RD) && avm.avm_readdatavalid && (rd_recv_q < iolen_q);
  assign rd_issued_nxt = rd_issued_q + 1'b1;
  assign rd_recv_nxt   = rd_recv_q + 1'b1;
  assign iolen_m1      = iolen_q - 1'b1;

  always_comb begin
    state_d     = state_q;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    iolen_d     = iolen_q;
    rd_issued_d = rd_issued_q;
    rd_recv_d   = rd_recv_q;
    wr_sent_d   = wr_sent_q;
    addr_d      = addr_q;
    read_d      = read_q;
    write_d     = write_q;
    done_d      = 1'b0;
    busy_d      = busy_q;
    buf_rd_en   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (config_done) begin
          raddr_d     = param_raddr;
          waddr_d     = param_waddr;
          iolen_d     = {1'b0, param_iolen};
          rd_issued_d = '0;
          rd_recv_d   = '0;
          wr_sent_d   = '0;
          busy_d      = 1'b1;
          if (param_iolen == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RD;
            read_d  = 1'b1;
            addr_d  = param_raddr;
          end
        end
      end

      S_RD: begin
        if (rd_acc) begin
          rd_issued_d = rd_issued_nxt;
          read_d      = (rd_issued_nxt < iolen_q);
          addr_d      = raddr_q + DW'({rd_issued_nxt, 2'b00});
        end
        if (rdv_acc) begin
          rd_recv_d = rd_recv_nxt;
          if (rd_recv_nxt == iolen_q) begin
            state_d = S_WR_LD;
            read_d  = 1'b0;
          end
        end
      end

      S_WR_LD: begin
        buf_rd_en = 1'b1;
        state_d   = S_WR;
        write_d   = 1'b1;
        addr_d    = waddr_q + DW'({wr_sent_q, 2'b00});
      end

      S_WR: begin
        if (wr_acc) begin
          wr_sent_d = wr_sent_q + 1'b1;
          write_d   = 1'b0;
          if (wr_sent_q == iolen_m1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_WR_LD;
          end
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      raddr_q     <= '0;
      waddr_q     <= '0;
      iolen_q     <= '0;
      rd_issued_q <= '0;
      rd_recv_q   <= '0;
      wr_sent_q   <= '0;
      addr_q      <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      raddr_q     <= raddr_d;
      waddr_q     <= waddr_d;
      iolen_q     <= iolen_d;
      rd_issued_q <= rd_issued_d;
      rd_recv_q   <= rd_recv_d;
      wr_sent_q   <= wr_sent_d;
      addr_q      <= addr_d;
      read_q      <= read_d;
      write_q     <= write_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  // Tile buffer: written by returning read data, read with one cycle of latency.
  always_ff @(posedge clk) begin
    if (rdv_acc) begin
      buf_mem[rd_recv_q[AW-1:0]] <= avm.avm_readdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_q <= '0;
    end else if (buf_rd_en) begin
      wdata_q <= buf_mem[wr_sent_q[AW-1:0]];
    end
  end

  assign store_data_done   = done_q;
  assign busy              = busy_q;
  assign dbg_state         = state_q;
  assign avm.avm_address   = addr_q;
  assign avm.avm_read      = read_q;
  assign avm.avm_write     = write_q;
  assign avm.avm_writedata = wdata_q;

endmodule
